dispensador_billetes: RTL and testbench

Cash-dispenser controller on the delivery side of the ATM transaction path. It accepts a withdrawal request: a one-cycle `entregar_dinero` strobe plus `monto`. It first plans the request greedily as 100/50/20/10 bills and rejects amounts it cannot pay out. Only then does it drive the bill mechanism one bill at a time over a req/ack handshake, and it reports completion, error and the number of bills delivered.

---
 rtl/dispensador_billetes_if.sv | 33 +++
 rtl/dispensador_billetes.sv | 249 ++++++++++++++++++++++++
 tb/tb_dispensador_billetes.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dispensador_billetes_if.sv
// -----------------------------------------------------------------------------
// dispensador_billetes_if
//   Bill-mechanism handshake between the dispenser controller and the
//   mechanism that physically delivers one bill at a time.
//
//   Signals:
//     bill_req   - controller requests the current bill (held until accepted)
//     bill_denom - denomination code of the current bill (0=largest .. 3=smallest),
//                  stable for as long as bill_req is high
//     bill_ack   - mechanism accepted the current bill; a transfer is any cycle
//                  with bill_req and bill_ack both high
//
//   Modports:
//     master - the controller (drives req/denom, receives ack)
//     slave  - the mechanism (receives req/denom, drives ack)
// -----------------------------------------------------------------------------
interface dispensador_billetes_if;
  logic       bill_req;
  logic [1:0] bill_denom;
  logic       bill_ack;

  modport master (
    output bill_req,
    output bill_denom,
    input  bill_ack
  );

  modport slave (
    input  bill_req,
    input  bill_denom,
    output bill_ack
  );
endinterface

// File: rtl/dispensador_billetes.sv
// -----------------------------------------------------------------------------
// dispensador_billetes
//   Cash-dispenser controller. A withdrawal request (one-cycle strobe plus
//   amount) is first planned greedily as DENOM_0/1/2/3 bills; amounts that are
//   not a multiple of the smallest bill, or that need more than MAX_BILLS
//   bills, are rejected before any bill is requested. Accepted requests are
//   paid out one bill at a time over the req/ack handshake of the bill
//   interface, and completion / error / bill count are reported.
//
//   Optional feature (compile-time macro DISPENSER_TIMEOUT_EN):
//     defined   - each bill must be acknowledged within ACK_TIMEOUT cycles of
//                 REQ, otherwise the request ends with error code 11.
//     undefined - REQ waits for the acknowledge indefinitely.
//
//   Ports:
//     clk               in   clock
//     reset             in   synchronous, active-low reset
//     entregar_dinero_i in   one-cycle dispense request strobe
//     monto_i           in   amount, sampled with the strobe
//     bill_if           master side of the bill handshake (req/denom/ack)
//     busy_o            out  high whenever the controller is not IDLE
//     dispense_done_o   out  one-cycle success pulse
//     dispense_error_o  out  one-cycle failure pulse
//     error_code_o      out  00 none, 01 not a multiple, 10 too many bills,
//                            11 mechanism timeout; held until next request
//     bills_dispensed_o out  bills acknowledged in the current/last request
// -----------------------------------------------------------------------------
module dispensador_billetes #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DENOM_0     = 100,
  parameter int unsigned DENOM_1     = 50,
  parameter int unsigned DENOM_2     = 20,
  parameter int unsigned DENOM_3     = 10,
  parameter int unsigned MAX_BILLS   = 40,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  entregar_dinero_i,
  input  logic [DATA_W-1:0]     monto_i,
  dispensador_billetes_if.master bill_if,
  output logic                  busy_o,
  output logic                  dispense_done_o,
  output logic                  dispense_error_o,
  output logic [1:0]            error_code_o,
  output logic [7:0]            bills_dispensed_o
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLAN   = 3'd1;
  localparam logic [2:0] S_SELECT = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_NOTMULT = 2'b01;
  localparam logic [1:0] ERR_TOOMANY = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [DATA_W-1:0] D0 = DATA_W'(DENOM_0);
  localparam logic [DATA_W-1:0] D1 = DATA_W'(DENOM_1);
  localparam logic [DATA_W-1:0] D2 = DATA_W'(DENOM_2);
  localparam logic [DATA_W-1:0] D3 = DATA_W'(DENOM_3);

  localparam logic [7:0] MAX_BILLS_C = 8'(MAX_BILLS);

  // ---------------------------------------------------------------------------
  // Greedy helpers
  // ---------------------------------------------------------------------------
  // Code of the largest denomination not exceeding r. Callers only use it
  // when r >= D3, so the fall-through to code 3 is always a valid choice.
  function automatic logic [1:0] pick_code(input logic [DATA_W-1:0] r);
    if (r >= D0)      return 2'd0;
    else if (r >= D1) return 2'd1;
    else if (r >= D2) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [DATA_W-1:0] denom_val(input logic [1:0] code);
    case (code)
      2'd0:    return D0;
      2'd1:    return D1;
      2'd2:    return D2;
      default: return D3;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]        state_q,    state_d;
  logic [DATA_W-1:0] amt_q,      amt_d;
  logic [DATA_W-1:0] rest_q,     rest_d;
  logic [7:0]        plan_cnt_q, plan_cnt_d;
  logic [7:0]        bills_q,    bills_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [1:0]        denom_q,    denom_d;
  logic              req_q,      req_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              error_q,    error_d;
`ifdef DISPENSER_TIMEOUT_EN
  logic [7:0]        tmo_q,      tmo_d;
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    amt_d      = amt_q;
    rest_d     = rest_q;
    plan_cnt_d = plan_cnt_q;
    bills_d    = bills_q;
    err_code_d = err_code_q;
    denom_d    = denom_q;
`ifdef DISPENSER_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (entregar_dinero_i) begin
          amt_d      = monto_i;
          rest_d     = monto_i;
          plan_cnt_d = 8'd0;
          bills_d    = 8'd0;
          err_code_d = ERR_NONE;
          state_d    = S_PLAN;
        end
      end

      // Dry run of the payout: nothing reaches the mechanism until the whole
      // amount is known to be payable, so a rejected request never leaves a
      // partial payout behind.
      S_PLAN: begin
        if (rest_q == '0) begin
          rest_d  = amt_q;
          state_d = S_SELECT;
        end else if (rest_q < D3) begin
          err_code_d = ERR_NOTMULT;
          state_d    = S_ERR;
        end else if (plan_cnt_q == MAX_BILLS_C) begin
          err_code_d = ERR_TOOMANY;
          state_d    = S_ERR;
        end else begin
          rest_d     = rest_q - denom_val(pick_code(rest_q));
          plan_cnt_d = plan_cnt_q + 8'd1;
        end
      end

      S_SELECT: begin
        if (rest_q == '0) begin
          state_d = S_DONE;
        end else begin
          denom_d = pick_code(rest_q);
`ifdef DISPENSER_TIMEOUT_EN
          tmo_d   = 8'd0;
`endif
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (bill_if.bill_ack) begin
          // denom_q was picked from rest_q, so this cannot underflow.
          rest_d  = rest_q - denom_val(denom_q);
          bills_d = bills_q + 8'd1;
          state_d = S_SELECT;
        end
`ifdef DISPENSER_TIMEOUT_EN
        // tmo_q counts completed REQ cycles; an ack in the last allowed
        // cycle still wins over the timeout.
        else if (tmo_q == TMO_LAST) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered and
    // line up exactly with the state they describe.
    busy_d  = (state_d != S_IDLE);
    req_d   = (state_d == S_REQ);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERR);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      amt_q      <= '0;
      rest_q     <= '0;
      plan_cnt_q <= 8'd0;
      bills_q    <= 8'd0;
      err_code_q <= ERR_NONE;
      denom_q    <= 2'd0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef DISPENSER_TIMEOUT_EN
      tmo_q      <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      amt_q      <= amt_d;
      rest_q     <= rest_d;
      plan_cnt_q <= plan_cnt_d;
      bills_q    <= bills_d;
      err_code_q <= err_code_d;
      denom_q    <= denom_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef DISPENSER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bill_if.bill_req   = req_q;
  assign bill_if.bill_denom = denom_q;
  assign busy_o             = busy_q;
  assign dispense_done_o    = done_q;
  assign dispense_error_o   = error_q;
  assign error_code_o       = err_code_q;
  assign bills_dispensed_o  = bills_q;

endmodule

// File: tb/tb_dispensador_billetes.sv
// -----------------------------------------------------------------------------
// tb_dispensador_billetes
//   Scoreboard bench for the cash-dispenser controller. Stimulus pushes the
//   expected end-of-request response and expected bill codes; a monitor on
//   the falling edge pops and compares whenever the DUT ends a request or
//   transfers a bill. A small mechanism model drives bill_ack.
// -----------------------------------------------------------------------------
module tb_dispensador_billetes;

  logic        clk;
  logic        reset;
  logic        strobe;
  logic [31:0] monto;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  ecode;
  logic [7:0]  bills;

  dispensador_billetes_if bif ();

  dispensador_billetes dut (
    .clk               (clk),
    .reset             (reset),
    .entregar_dinero_i (strobe),
    .monto_i           (monto),
    .bill_if           (bif),
    .busy_o            (busy),
    .dispense_done_o   (done),
    .dispense_error_o  (err),
    .error_code_o      (ecode),
    .bills_dispensed_o (bills)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] bills;
    int         e0;
    int         end_rel;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] dq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int cur_e0        = 0;
  int cur_first_rel = -1;
  bit first_seen    = 1'b1;

  // mechanism model controls
  bit ack_tie   = 1'b1;
  int ack_delay = 0;
  int ack_limit = 1000;
  int acks_given = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Mechanism model: ack after ack_delay waiting REQ cycles, at most
  // ack_limit acks, or ack tied high.
  // ---------------------------------------------------------------------------
  initial begin
    int wcnt;
    wcnt = 0;
    bif.bill_ack = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ack_tie) begin
        bif.bill_ack = 1'b1;
      end else if (bif.bill_req && acks_given < ack_limit) begin
        if (wcnt >= ack_delay) begin
          bif.bill_ack = 1'b1;
          acks_given++;
        end else begin
          bif.bill_ack = 1'b0;
          wcnt++;
        end
      end else begin
        bif.bill_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    logic       prev_req;
    logic       prev_xfer;
    logic [1:0] prev_denom;
    exp_t       e;
    prev_req   = 1'b0;
    prev_xfer  = 1'b0;
    prev_denom = 2'd0;
    forever begin
      @(negedge clk);
      if (done || err) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_end: got done=%0d error=%0d expected none", done, err);
        end else begin
          e = sb.pop_front();
          chk("end_is_error", 32'(err), 32'(e.is_err));
          chk("end_is_done", 32'(done), 32'(!e.is_err));
          chk("error_code", 32'(ecode), 32'(e.code));
          chk("bills_dispensed", 32'(bills), 32'(e.bills));
          if (e.end_rel >= 0) chk("end_latency", 32'(cyc - e.e0), 32'(e.end_rel));
          chk("denoms_left", 32'(dq.size()), 32'd0);
        end
      end
      if (bif.bill_req && bif.bill_ack) begin
        if (dq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_bill: got code %0d expected no bill", bif.bill_denom);
        end else begin
          chk("bill_denom", 32'(bif.bill_denom), 32'(dq.pop_front()));
        end
      end
      if (bif.bill_req && prev_req && !prev_xfer)
        chk("denom_stable", 32'(bif.bill_denom), 32'(prev_denom));
      if (bif.bill_req && !prev_req && !first_seen) begin
        first_seen = 1'b1;
        if (cur_first_rel >= 0) chk("first_req", 32'(cyc - cur_e0), 32'(cur_first_rel));
      end
      prev_req   = bif.bill_req;
      prev_xfer  = bif.bill_req && bif.bill_ack;
      prev_denom = bif.bill_denom;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called right after a rising edge + #1)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [31:0] amt, input bit is_err, input logic [1:0] code,
                       input logic [7:0] nb, input int first_rel, input int end_rel);
    exp_t e;
    e.is_err  = is_err;
    e.code    = code;
    e.bills   = nb;
    e.e0      = cyc + 1;
    e.end_rel = end_rel;
    sb.push_back(e);
    cur_e0        = cyc + 1;
    cur_first_rel = first_rel;
    first_seen    = 1'b0;
    strobe = 1'b1;
    monto  = amt;
    @(posedge clk);
    #1;
    strobe = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: got %0d pending after %0d cycles expected 0", sb.size(), budget);
      sb.delete();
      dq.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bill_req"}, 32'(bif.bill_req), 32'd0);
    chk({tag, "_bill_denom"}, 32'(bif.bill_denom), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(err), 32'd0);
    chk({tag, "_error_code"}, 32'(ecode), 32'd0);
    chk({tag, "_bills"}, 32'(bills), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    reset  = 1'b0;
    strobe = 1'b0;
    monto  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 180 = 100+50+20+10, ack tied high: N=4, first req E0+6, done E0+14
    ack_tie = 1'b1;
    dq.push_back(2'd0); dq.push_back(2'd1); dq.push_back(2'd2); dq.push_back(2'd3);
    issue(32'd180, 1'b0, 2'b00, 8'd4, 6, 14);
    wait_done(100);

    // 155: 100, 50, then 5 left -> not a multiple, reported at E0+3
    issue(32'd155, 1'b1, 2'b01, 8'd0, -1, 3);
    wait_done(50);

    // 4100: 40 bills still leave 100 -> too many, reported at E0+41
    issue(32'd4100, 1'b1, 2'b10, 8'd0, -1, 41);
    wait_done(100);

    // 4000: exactly 40 bills of 100; first req E0+42, done E0+122
    for (int i = 0; i < 40; i++) dq.push_back(2'd0);
    issue(32'd4000, 1'b0, 2'b00, 8'd40, 42, 122);
    wait_done(300);

    // zero amount: done at E0+2, then a new strobe in the first IDLE cycle
    issue(32'd0, 1'b0, 2'b00, 8'd0, -1, 2);
    repeat (3) @(posedge clk);
    #1;
    issue(32'd0, 1'b0, 2'b00, 8'd0, -1, 2);
    wait_done(50);

    // 60 = 50+10 with ack after 3 waiting cycles; a strobe while busy is ignored
    ack_tie   = 1'b0;
    ack_delay = 3;
    ack_limit = 1000;
    acks_given = 0;
    dq.push_back(2'd1); dq.push_back(2'd3);
    issue(32'd60, 1'b0, 2'b00, 8'd2, 4, 14);
    repeat (4) @(posedge clk);
    #1;
    chk("busy_during_req", 32'(busy), 32'd1);
    strobe = 1'b1;
    monto  = 32'd100;
    @(posedge clk);
    #1;
    strobe = 1'b0;
    wait_done(100);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_after_ignored", 32'(busy), 32'd0);

`ifdef DISPENSER_TIMEOUT_EN
    // 60 with the second bill never acked: first bill transfers at E0+5,
    // second REQ starts after E0+6, timeout after 255 REQ cycles -> E0+261
    ack_delay  = 0;
    ack_limit  = 1;
    acks_given = 0;
    dq.push_back(2'd1);
    issue(32'd60, 1'b1, 2'b11, 8'd1, 4, 261);
    wait_done(400);
`endif

    // reset while waiting in REQ for the second bill of 60
    ack_tie    = 1'b0;
    ack_delay  = 0;
    ack_limit  = 1;
    acks_given = 0;
    dq.push_back(2'd1);
    issue(32'd60, 1'b0, 2'b00, 8'd2, 4, -1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (bif.bill_req && bills == 8'd1) begin
          seen = 1'b1;
          break;
        end
        @(posedge clk);
        #1;
      end
      chk("reached_second_req", 32'(seen), 32'd1);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midreq_reset");
    sb.delete();
    dq.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 100 after the reset: N=1, first req E0+3, done E0+5
    ack_tie = 1'b1;
    dq.push_back(2'd0);
    issue(32'd100, 1'b0, 2'b00, 8'd1, 3, 5);
    wait_done(50);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
